// File: rtl/hazard_pipe_regs.sv
// -----------------------------------------------------------------------------
// hazard_pipe_regs
//
// Purpose:
//   Consumer end of the load-use hazard interface. Holds the PC register, the
//   IF/ID pipeline register and the subset of the ID/EX register that hazard
//   detection looks at. It applies hold (freeze PC + IF/ID), bubble (zero
//   ID/EX) and branch flush (squash IF/ID). It feeds ID_EXMemRead/ID_EXRt back
//   to the hazard detector and runs a stall watchdog.
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN - when defined, stall_count and flush_count are
//   saturating performance counters. When undefined they are tied to zero and
//   no counter flops exist. The port list is the same in both builds.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   IF_IDhold                freeze PC and IF/ID this edge
//   ID_EXzero                load a NOP bubble into ID/EX this edge
//   IF_flush                 squash IF/ID (taken branch in ID); ignored on hold
//   PC_next                  next PC from the fetch/branch mux
//   IF_instr                 instruction memory output
//   ID_ctrl, ID_Rs/Rt/Rd     decoded control bundle and register numbers
//   ID_rdata1/2              register file read data
//   PC                       current PC
//   IF_IDinstr, IF_IDpc4     IF/ID contents
//   ID_EX*                   ID/EX contents; ID_EXMemRead is ID_EXctrl[0]
//   stall_run                consecutive-hold counter (saturates at 15)
//   stall_err                sticky watchdog flag, cleared only by rst
//   stall_count, flush_count performance counters (optional build)
// -----------------------------------------------------------------------------
module hazard_pipe_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 8,
  parameter int          MAX_STALL = 2,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IF_IDhold,
  input  logic              ID_EXzero,
  input  logic              IF_flush,
  input  logic [31:0]       PC_next,
  input  logic [31:0]       IF_instr,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic [31:0]       ID_rdata1,
  input  logic [31:0]       ID_rdata2,
  output logic [31:0]       PC,
  output logic [31:0]       IF_IDinstr,
  output logic [31:0]       IF_IDpc4,
  output logic [CTRL_W-1:0] ID_EXctrl,
  output logic              ID_EXMemRead,
  output logic [4:0]        ID_EXRs,
  output logic [4:0]        ID_EXRt,
  output logic [4:0]        ID_EXRd,
  output logic [31:0]       ID_EXrdata1,
  output logic [31:0]       ID_EXrdata2,
  output logic [3:0]        stall_run,
  output logic              stall_err,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // stall_run value seen on the edge that completes the MAX_STALL-th hold.
  localparam logic [3:0] STALL_TRIP = 4'(MAX_STALL - 1);
  localparam logic [3:0] RUN_MAX    = 4'hF;

  // ---------------------------------------------------------------------------
  // PC and IF/ID
  // ---------------------------------------------------------------------------
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic [31:0] w_pc_plus4;
  logic        w_flush_eff;

  // 32-bit add wraps naturally, so 32'hFFFF_FFFC + 4 gives 0.
  assign w_pc_plus4  = r_pc + 32'd4;
  // A flush arriving during a hold is dropped; the branch unit re-presents it.
  assign w_flush_eff = IF_flush & ~IF_IDhold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
    end else if (IF_IDhold) begin
      r_pc         <= r_pc;
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc4   <= r_ifid_pc4;
    end else if (IF_flush) begin
      r_pc         <= PC_next;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
    end else begin
      r_pc         <= PC_next;
      r_ifid_instr <= IF_instr;
      r_ifid_pc4   <= w_pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX subset. A bubble zeroes everything, including MemRead, so the
  // hazard detector sees no load in EX on the following cycle.
  // ---------------------------------------------------------------------------
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic [4:0]        r_idex_rs;
  logic [4:0]        r_idex_rt;
  logic [4:0]        r_idex_rd;
  logic [31:0]       r_idex_rdata1;
  logic [31:0]       r_idex_rdata2;

  always_ff @(posedge clk) begin
    if (rst || ID_EXzero) begin
      r_idex_ctrl   <= '0;
      r_idex_rs     <= 5'd0;
      r_idex_rt     <= 5'd0;
      r_idex_rd     <= 5'd0;
      r_idex_rdata1 <= 32'd0;
      r_idex_rdata2 <= 32'd0;
    end else begin
      r_idex_ctrl   <= ID_ctrl;
      r_idex_rs     <= ID_Rs;
      r_idex_rt     <= ID_Rt;
      r_idex_rd     <= ID_Rd;
      r_idex_rdata1 <= ID_rdata1;
      r_idex_rdata2 <= ID_rdata2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
  logic [3:0] r_stall_run;
  logic       r_stall_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_run <= 4'd0;
      r_stall_err <= 1'b0;
    end else if (IF_IDhold) begin
      if (r_stall_run != RUN_MAX) begin
        r_stall_run <= r_stall_run + 4'd1;
      end
      if (r_stall_run == STALL_TRIP) begin
        r_stall_err <= 1'b1;
      end
    end else begin
      r_stall_run <= 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (optional build)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (IF_IDhold && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_flush_eff && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  logic w_unused_flush;
  assign w_unused_flush = w_flush_eff;
  assign stall_count    = '0;
  assign flush_count    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: every output comes straight from a flop.
  // ---------------------------------------------------------------------------
  assign PC           = r_pc;
  assign IF_IDinstr   = r_ifid_instr;
  assign IF_IDpc4     = r_ifid_pc4;
  assign ID_EXctrl    = r_idex_ctrl;
  assign ID_EXMemRead = r_idex_ctrl[0];
  assign ID_EXRs      = r_idex_rs;
  assign ID_EXRt      = r_idex_rt;
  assign ID_EXRd      = r_idex_rd;
  assign ID_EXrdata1  = r_idex_rdata1;
  assign ID_EXrdata2  = r_idex_rdata2;
  assign stall_run    = r_stall_run;
  assign stall_err    = r_stall_err;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
// -----------------------------------------------------------------------------
// tb_hazard_pipe_regs
//
// Self-checking bench for hazard_pipe_regs. A behavioural model tracks the
// expected architectural state (PC, IF/ID, ID/EX, hold streak, event counts)
// and every output is compared after each clock edge. The directed sections
// are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_pipe_regs;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          CTRL_W    = 8;
  localparam int          MAX_STALL = 2;
  localparam int          CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              IF_IDhold, ID_EXzero, IF_flush;
  logic [31:0]       PC_next, IF_instr;
  logic [CTRL_W-1:0] ID_ctrl;
  logic [4:0]        ID_Rs, ID_Rt, ID_Rd;
  logic [31:0]       ID_rdata1, ID_rdata2;
  logic [31:0]       PC, IF_IDinstr, IF_IDpc4;
  logic [CTRL_W-1:0] ID_EXctrl;
  logic              ID_EXMemRead;
  logic [4:0]        ID_EXRs, ID_EXRt, ID_EXRd;
  logic [31:0]       ID_EXrdata1, ID_EXrdata2;
  logic [3:0]        stall_run;
  logic              stall_err;
  logic [CNT_W-1:0]  stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_pipe_regs #(
    .RESET_PC (RESET_PC),
    .CTRL_W   (CTRL_W),
    .MAX_STALL(MAX_STALL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IF_IDhold   (IF_IDhold),
    .ID_EXzero   (ID_EXzero),
    .IF_flush    (IF_flush),
    .PC_next     (PC_next),
    .IF_instr    (IF_instr),
    .ID_ctrl     (ID_ctrl),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_Rd       (ID_Rd),
    .ID_rdata1   (ID_rdata1),
    .ID_rdata2   (ID_rdata2),
    .PC          (PC),
    .IF_IDinstr  (IF_IDinstr),
    .IF_IDpc4    (IF_IDpc4),
    .ID_EXctrl   (ID_EXctrl),
    .ID_EXMemRead(ID_EXMemRead),
    .ID_EXRs     (ID_EXRs),
    .ID_EXRt     (ID_EXRt),
    .ID_EXRd     (ID_EXRd),
    .ID_EXrdata1 (ID_EXrdata1),
    .ID_EXrdata2 (ID_EXrdata2),
    .stall_run   (stall_run),
    .stall_err   (stall_err),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [31:0]       m_pc, m_instr, m_pc4;
  logic [CTRL_W-1:0] m_ctrl;
  logic [4:0]        m_rs, m_rt, m_rd;
  logic [31:0]       m_rd1, m_rd2;
  int                m_consec;   // unbounded length of the current hold streak
  bit                m_err;
  int                m_holds;    // total hold edges since reset
  int                m_flushes;  // total effective flushes since reset

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic rand_inputs();
    PC_next   = $urandom;
    IF_instr  = $urandom;
    ID_ctrl   = CTRL_W'($urandom);
    ID_Rs     = 5'($urandom);
    ID_Rt     = 5'($urandom);
    ID_Rd     = 5'($urandom);
    ID_rdata1 = $urandom;
    ID_rdata2 = $urandom;
  endtask

  task automatic ctl(input logic r, input logic h, input logic z, input logic f);
    rst = r; IF_IDhold = h; ID_EXzero = z; IF_flush = f;
  endtask

  // Advance the model with the current inputs, clock the DUT, compare all.
  task automatic tick(input string tag);
    if (rst) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0;
      m_consec = 0; m_err = 0; m_holds = 0; m_flushes = 0;
    end else if (IF_IDhold) begin
      m_consec++;
      m_holds++;
      if (m_consec >= MAX_STALL) m_err = 1;
    end else begin
      m_consec = 0;
      if (IF_flush) begin
        m_instr = 0; m_pc4 = 0; m_flushes++;
      end else begin
        m_instr = IF_instr; m_pc4 = m_pc + 32'd4;
      end
      m_pc = PC_next;
    end
    if (rst || ID_EXzero) begin
      m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0;
    end else begin
      m_ctrl = ID_ctrl; m_rs = ID_Rs; m_rt = ID_Rt; m_rd = ID_Rd;
      m_rd1 = ID_rdata1; m_rd2 = ID_rdata2;
    end
    @(posedge clk);
    #1;
    check_val({tag, ".PC"},        PC,                  m_pc);
    check_val({tag, ".instr"},     IF_IDinstr,          m_instr);
    check_val({tag, ".pc4"},       IF_IDpc4,            m_pc4);
    check_val({tag, ".ctrl"},      32'(ID_EXctrl),      32'(m_ctrl));
    check_val({tag, ".memread"},   32'(ID_EXMemRead),   32'(m_ctrl[0]));
    check_val({tag, ".rs"},        32'(ID_EXRs),        32'(m_rs));
    check_val({tag, ".rt"},        32'(ID_EXRt),        32'(m_rt));
    check_val({tag, ".rd"},        32'(ID_EXRd),        32'(m_rd));
    check_val({tag, ".rdata1"},    ID_EXrdata1,         m_rd1);
    check_val({tag, ".rdata2"},    ID_EXrdata2,         m_rd2);
    check_val({tag, ".stall_run"}, 32'(stall_run),      32'(sat(m_consec, 15)));
    check_val({tag, ".stall_err"}, 32'(stall_err),      32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, ".stall_cnt"}, 32'(stall_count),    32'(sat(m_holds, CNT_MAX)));
    check_val({tag, ".flush_cnt"}, 32'(flush_count),    32'(sat(m_flushes, CNT_MAX)));
`else
    check_val({tag, ".stall_cnt"}, 32'(stall_count),    32'd0);
    check_val({tag, ".flush_cnt"}, 32'(flush_count),    32'd0);
`endif
    $display("tick %-8s rst=%0b hold=%0b zero=%0b flush=%0b PC=%h instr=%h pc4=%h run=%0d err=%0b",
             tag, rst, IF_IDhold, ID_EXzero, IF_flush, PC, IF_IDinstr, IF_IDpc4, stall_run, stall_err);
  endtask

  logic [31:0] wrap_exp [3];
  logic [31:0] saved_pc, saved_instr;

  initial begin
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rd1 = 0; m_rd2 = 0; m_consec = 0; m_err = 0; m_holds = 0; m_flushes = 0;
    rand_inputs();
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset with random inputs on the control lines too.
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      ctl(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      tick("reset");
    end
    check_val("reset.pc_const", PC, 32'h0);

    // Straight-line fetch across the 32-bit PC wrap.
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b0);
    PC_next = 32'hFFFF_FFF8;
    tick("wrapset");
    wrap_exp[0] = 32'hFFFF_FFFC; wrap_exp[1] = 32'h0; wrap_exp[2] = 32'h4;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      PC_next = PC + 32'd4;
      tick("wrap");
      check_val("wrap.pc4_seq", IF_IDpc4, wrap_exp[i]);
    end

    // Load-use stall: one hold+bubble with a load sitting in ID.
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b0);
    ID_ctrl = 8'h05;
    tick("preload");
    check_val("preload.memread", 32'(ID_EXMemRead), 32'd1);
    saved_pc = PC; saved_instr = IF_IDinstr;
    rand_inputs(); ctl(1'b0, 1'b1, 1'b1, 1'b0);
    ID_ctrl = 8'h05;
    tick("loaduse");
    check_val("loaduse.pc_frozen", PC, saved_pc);
    check_val("loaduse.instr_frozen", IF_IDinstr, saved_instr);
    check_val("loaduse.run1", 32'(stall_run), 32'd1);
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick("release");
    check_val("release.run0", 32'(stall_run), 32'd0);
    check_val("release.err0", 32'(stall_err), 32'd0);

    // Flush, then a flush masked by hold.
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b1);
    IF_instr = 32'h8C22_0004; PC_next = 32'h100;
    tick("flush");
    check_val("flush.instr0", IF_IDinstr, 32'h0);
    check_val("flush.pc100", PC, 32'h100);
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick("refill");
    saved_pc = PC; saved_instr = IF_IDinstr;
    rand_inputs(); ctl(1'b0, 1'b1, 1'b0, 1'b1);
    tick("holdflsh");
    check_val("holdflush.pc", PC, saved_pc);
    check_val("holdflush.instr", IF_IDinstr, saved_instr);

    // Watchdog: three consecutive holds, then release, then reset.
    rand_inputs(); ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick("wdreset");
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); ctl(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      tick("wdhold");
      check_val("wd.err_edge", 32'(stall_err), (i >= 1) ? 32'd1 : 32'd0);
    end
    rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick("wdrel");
    check_val("wd.sticky", 32'(stall_err), 32'd1);
    rand_inputs(); ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick("wdclear");
    check_val("wd.cleared", 32'(stall_err), 32'd0);

    // Perf counters: 20 holds, reset, 3 effective flushes.
    for (int i = 0; i < 20; i++) begin
      rand_inputs(); ctl(1'b0, 1'b1, 1'b0, 1'b0);
      tick("perfhold");
    end
    rand_inputs(); ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick("perfrst");
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); ctl(1'b0, 1'b0, 1'b0, 1'b1);
      tick("perfflsh");
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      ctl(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
